sha256_overall: RTL and testbench
=================================

# sha256_overall

- Single-block SHA-256 compression engine: computes the 256-bit digest of one pre-padded 512-bit message block from the standard SHA-256 initial hash values.
- Sits behind a memory-mapped peripheral wrapper. Software drives `message` and `reset`, polls `ready`, then reads `hashvalue`.
- One round per clock, using an iterative datapath and a 16-word rolling message schedule.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (`reset`=0 clears all state immediately; operation starts when released).
- `message` in 512, declared `[0:511]`: pre-padded block, big-endian. `message[0:31]` is W0, with `message[0]` as its MSB; `message[480:511]` is W15.
- `ready` out 1: digest valid; sticky until next reset.
- `hashvalue` out 256: digest. `[255:224]`=H0 … `[31:0]`=H7.

## Operation
- States: LOAD, ROUND, DONE.
- While `reset`=0:
  - state=LOAD, `ready`=0, `hashvalue`=0.
  - Round counter=0; working registers and schedule cleared.
- LOAD (first rising edge after release):
  - Copy W0..W15 from `message` into the schedule window.
  - Set a..h to the standard IV: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
  - Set t=0; go to ROUND.
- ROUND (64 edges, t=0..63), one standard SHA-256 round per edge:
  - T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W[t].
  - T2 = Σ0(a)+Maj(a,b,c).
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Schedule window shifts each round; new word = σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
  - K[0..63] is the standard constant table (ROM/case).
  - After t=63, go to DONE.
- DONE (first edge):
  - `hashvalue` ← {IV0+a, …, IV7+h}; `ready` ← 1.
  - Then hold both indefinitely; further `message` changes are ignored.
- Arithmetic: all additions mod 2^32, with no carries across words.
- Functions:
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
  - σ0 = ROTR7^ROTR18^SHR3.
  - σ1 = ROTR17^ROTR19^SHR10.
- `message` is sampled only in LOAD. Changes during ROUND/DONE have no effect.
- Multi-block chaining and padding are out of scope; software supplies an already padded single block.

## Timing
- Reset values: `ready`=0, `hashvalue`=256'h0.
- Latency, with edge E0 = first rising edge with `reset`=1:
  - E0 = LOAD.
  - E1..E64 = rounds.
  - E65 = `ready` and `hashvalue` update together.
  - `ready` is visible after E65, i.e. 66 edges after release.
- `hashvalue` never shows intermediate values; it stays 0 until the same edge `ready` rises.
- Reset asserted mid-operation: immediate asynchronous abort. Outputs return to 0 without waiting for a clock. Computation restarts from LOAD after release, using `message` present at that E0.
- Reset asserted in DONE clears `ready` and `hashvalue` immediately.
- No handshake on `message`: it must be stable on the E0 setup/hold window.

## Test plan
- "abc" block: W0=61626380, W1..W14=0, W15=00000018; reset pulse low, then release.
  - → `ready`=0 through E64, 1 after E65.
  - → `hashvalue`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty-string block: W0=80000000, rest 0.
  - → `hashvalue`=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855 after 66 edges.
- Mid-operation reset: start "abc", assert `reset`=0 at E30 between edges, switch `message` to the empty block, release.
  - → outputs 0 immediately; `ready` 66 edges after the new release; empty-string digest.
- Message change after E0: start "abc", change `message` to the empty block at E10.
  - → "abc" digest unaffected.
- Hold in DONE: after `ready`, run 100 extra clocks with random `message`.
  - → `ready` stays 1, `hashvalue` unchanged.
  - Then `reset`=0 → `ready`=0 and `hashvalue`=0 asynchronously.

Source files
------------

// File: rtl/sha256_overall.sv
// Single-block SHA-256 engine: one pre-padded 512-bit block hashed from the standard IV.
// Ports: clk, reset (async active-low), message[0:511] (W0 at message[0:31]), ready, hashvalue (H0 in [255:224]).
// Latency: LOAD on E0, 64 rounds on E1..E64, digest and ready together on E65; message sampled only in LOAD.
module sha256_overall (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:511] message,
    output logic         ready,
    output logic [255:0] hashvalue
);

    typedef enum logic [1:0] {LOAD, ROUND, DONE} state_t;

    localparam logic [31:0] IV0 = 32'h6a09e667;
    localparam logic [31:0] IV1 = 32'hbb67ae85;
    localparam logic [31:0] IV2 = 32'h3c6ef372;
    localparam logic [31:0] IV3 = 32'ha54ff53a;
    localparam logic [31:0] IV4 = 32'h510e527f;
    localparam logic [31:0] IV5 = 32'h9b05688c;
    localparam logic [31:0] IV6 = 32'h1f83d9ab;
    localparam logic [31:0] IV7 = 32'h5be0cd19;

    state_t      state;
    state_t      state_next;
    logic [5:0]  t;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w [16];      // rolling window: w[0] is W[t], w[15] is W[t+15]
    logic [31:0] t1, t2, w_new, k_t;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    // Round datapath and next schedule word (W[t+16] from W[t+14], W[t+9], W[t+1], W[t])
    always_comb begin
        k_t   = k_rom(t);
        t1    = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k_t + w[0];
        t2    = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = ROUND;
            ROUND:   if (t == 6'd63) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t         <= 6'd0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= 32'h0;
            ready     <= 1'b0;
            hashvalue <= 256'h0;
        end else begin
            case (state)
                LOAD: begin
                    for (int i = 0; i < 16; i++) w[i] <= message[i*32 +: 32];
                    {a, b, c, d, e, f, g, h} <= {IV0, IV1, IV2, IV3, IV4, IV5, IV6, IV7};
                    t <= 6'd0;
                end
                ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    t <= t + 6'd1;
                end
                DONE: begin
                    // Publish once; afterwards the outputs simply hold.
                    if (!ready) begin
                        hashvalue <= {IV0 + a, IV1 + b, IV2 + c, IV3 + d,
                                      IV4 + e, IV5 + f, IV6 + g, IV7 + h};
                        ready     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_overall.sv
module tb_sha256_overall;

    logic         clk;
    logic         reset;
    logic [0:511] message;
    logic         ready;
    logic [255:0] hashvalue;

    int checks   = 0;
    int failures = 0;

    sha256_overall dut (
        .clk       (clk),
        .reset     (reset),
        .message   (message),
        .ready     (ready),
        .hashvalue (hashvalue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV_TAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: full 64-word schedule, then 64 rounds over an array of working words.
    function automatic logic [255:0] sha_ref(input logic [511:0] blk);
        logic [31:0] wk [64];
        logic [31:0] v  [8];
        logic [31:0] s0, s1, x1, x2;
        logic [255:0] out;
        for (int i = 0; i < 16; i++) wk[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(wk[i-15], 7) ^ rotr(wk[i-15], 18) ^ (wk[i-15] >> 3);
            s1 = rotr(wk[i-2], 17) ^ rotr(wk[i-2], 19) ^ (wk[i-2] >> 10);
            wk[i] = wk[i-16] + s0 + wk[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = IV_TAB[i];
        for (int r = 0; r < 64; r++) begin
            x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[r] + wk[r];
            x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) out[255 - 32*i -: 32] = IV_TAB[i] + v[i];
        return out;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_dig(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset low between edges, present blk, release on a falling edge (next rising edge is E0).
    task automatic start(input logic [511:0] blk);
        @(negedge clk);
        reset   = 1'b0;
        message = blk;
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [255:0] held;
    logic [511:0] rblk;

    initial begin
        reset   = 1'b0;
        message = '0;
        #12;
        check_bit("reset_ready", ready, 1'b0);
        check_dig("reset_hash", hashvalue, 256'h0);

        // "abc": outputs stay 0 through E64, digest appears on E65
        start(ABC_BLK);
        for (int i = 0; i < 65; i++) begin
            edges(1);
            check_bit("abc_ready_low", ready, 1'b0);
            check_dig("abc_hash_zero", hashvalue, 256'h0);
        end
        edges(1);
        check_bit("abc_ready", ready, 1'b1);
        check_dig("abc_digest", hashvalue, ABC_DIG);

        // Empty string
        start(EMPTY_BLK);
        check_bit("empty_ready_cleared", ready, 1'b0);
        edges(65);
        check_bit("empty_ready_e64", ready, 1'b0);
        edges(1);
        check_bit("empty_ready", ready, 1'b1);
        check_dig("empty_digest", hashvalue, EMPTY_DIG);

        // Mid-operation abort at E30, restart on the empty block
        start(ABC_BLK);
        edges(31);
        #2;
        reset = 1'b0;
        #1;
        check_bit("abort_ready", ready, 1'b0);
        check_dig("abort_hash", hashvalue, 256'h0);
        message = EMPTY_BLK;
        @(negedge clk);
        reset = 1'b1;
        edges(65);
        check_bit("abort_ready_e64", ready, 1'b0);
        edges(1);
        check_bit("abort_ready_done", ready, 1'b1);
        check_dig("abort_digest", hashvalue, EMPTY_DIG);

        // Message change at E10 must not affect the result
        start(ABC_BLK);
        edges(11);
        message = EMPTY_BLK;
        edges(55);
        check_bit("late_change_ready", ready, 1'b1);
        check_dig("late_change_digest", hashvalue, ABC_DIG);

        // Hold in DONE with random message traffic, then asynchronous clear
        held = hashvalue;
        for (int i = 0; i < 100; i++) begin
            message = rand_blk();
            edges(1);
        end
        check_bit("hold_ready", ready, 1'b1);
        check_dig("hold_hash", hashvalue, held);
        #2;
        reset = 1'b0;
        #1;
        check_bit("done_clear_ready", ready, 1'b0);
        check_dig("done_clear_hash", hashvalue, 256'h0);

        // Random blocks against the reference model
        for (int n = 0; n < 6; n++) begin
            rblk = rand_blk();
            start(rblk);
            edges(65);
            check_bit("rand_ready_e64", ready, 1'b0);
            edges(1);
            check_bit("rand_ready", ready, 1'b1);
            check_dig("rand_digest", hashvalue, sha_ref(rblk));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
